rtc_ctrl: RTL and testbench
===========================

// Module: rtc_ctrl
// PURPOSE
//  Wishbone-controlled sequencer for the BCD real-time-clock counter chain (hh:mm:ss).
//  - Generates the one-cycle seconds tick from the bus clock through a programmable prescaler.
//  - Validates and loads a new time, and raises an alarm interrupt on a time match.
//  - Sits between the management SoC Wishbone bus and the RTC datapath in the user project.
// PARAMETERS
//  BASE_ADDR     32'h3000_0000  Wishbone base; registers at BASE_ADDR + {0x00..0x14}
//  PRESCALE_W    24             prescaler counter/register width
//  PRESCALE_RST  24'd9_999_999  reset value of PRESCALE (1 Hz tick at 10 MHz)
// PORTS
//  wb_clk_i     in   1   sole clock, rising edge
//  wb_rst_i     in   1   asynchronous, active-high reset
//  wbs_cyc_i    in   1   Wishbone cycle
//  wbs_stb_i    in   1   Wishbone strobe
//  wbs_we_i     in   1   1 = write
//  wbs_sel_i    in   4   byte enables; a lane with sel=0 leaves that byte unchanged
//  wbs_adr_i    in   32  byte address
//  wbs_dat_i    in   32  write data
//  wbs_ack_o    out  1   one-cycle acknowledge
//  wbs_dat_o    out  32  read data, valid with ack
//  time_i       in   24  live BCD time {hrm,hrl,minm,minl,secm,secl}, 4 bits per digit
//  tick_o       out  1   one-cycle seconds enable to the counter chain
//  load_o       out  1   one-cycle parallel-load strobe to the counter chain
//  load_time_o  out  24  BCD value to load; stable while load_o=1
//  irq_o        out  1   alarm interrupt, level
// BEHAVIOUR
//  Reset values:
//  - All outputs are 0; RUN=0, ALARM_EN=0, ALARM=0, STATUS=0, PRESCALE=PRESCALE_RST.
//  Registers (offset):
//  - 0x00 CTRL: [0] RUN, [1] ALARM_EN.
//  - 0x04 SET_TIME: write only; reads 0.
//  - 0x08 ALARM: 24-bit BCD.
//  - 0x0C STATUS: [0] ALARM_FLAG, W1C; [1] SET_ERR, W1C.
//  - 0x10 TIME: read only; returns time_i.
//  - 0x14 PRESCALE.
//  - Unused register bits read 0. Unmapped offsets ack, ignore writes and read 0.
//  Bus:
//  - wbs_ack_o is registered: asserted for exactly one cycle, the cycle after cyc&stb&!ack is seen.
//  - A held strobe therefore acks every second cycle.
//  - The write takes effect on the edge that raises ack.
//  Prescaler:
//  - While RUN=1, cnt increments each cycle.
//  - When cnt==PRESCALE, tick_o=1 for one cycle and cnt returns to 0. PRESCALE=0 ticks every cycle.
//  - RUN=0: cnt holds its value and tick_o=0.
//  - A PRESCALE write below the current cnt takes effect at the next wrap; cnt wraps at 2^PRESCALE_W-1.
//  SET_TIME validation: digit limits hrm<=2, hrl<=9, minm<=5, minl<=9, secm<=5, secl<=9.
//  - hrm==2 additionally requires hrl<=3.
//  - Invalid value: SET_ERR=1; no load; state unchanged.
//  FSM states and transitions:
//  - S_STOP -> S_RUN when RUN=1. S_RUN -> S_STOP when RUN=0.
//  - Valid SET_TIME write, from either state -> S_LOAD.
//  - S_LOAD lasts exactly one cycle: load_o=1, load_time_o=written value, tick_o forced 0, cnt cleared.
//  - S_LOAD then goes to S_RUN if RUN=1, else S_STOP.
//  - First tick after a load arrives PRESCALE+1 cycles after load_o.
//  - load_time_o holds its last value outside S_LOAD.
//  Alarm:
//  - match = (time_i==ALARM) & ALARM_EN, registered.
//  - ALARM_FLAG sets on the rising edge of match only, so it fires once per match.
//  - irq_o = ALARM_FLAG & ALARM_EN.
//  - Set and W1C clear in the same cycle: set wins.
//  - Clearing ALARM_EN masks irq_o but keeps ALARM_FLAG.
//  Reset mid-operation: asynchronous return to reset values; any load in progress is dropped.
// STRUCTURE
//  - Shared defines file rtc_defs.vh: register offsets, CTRL/STATUS bit indices, BCD digit
//    field positions and limits, FSM state encodings (S_STOP/S_RUN/S_LOAD).
//  - One sub-module rtc_prescaler (cnt, PRESCALE compare, tick, clear/hold inputs).
//  - Bus decode, BCD validator, FSM and alarm logic live in rtc_ctrl.
// TESTING
//  1. Reset, then read PRESCALE -> 0x0098967F; read CTRL/STATUS -> 0; tick_o, irq_o stay 0.
//  2. PRESCALE=3, CTRL=1 -> tick_o every 4th cycle. CTRL=0 -> ticks stop; cnt holds and resumes.
//  3. Write SET_TIME=0x235959 -> load_o one cycle with load_time_o=0x235959, then the next
//     tick exactly PRESCALE+1 cycles later.
//  4. Write SET_TIME=0x240000 or 0x126000 -> STATUS=0x2, no load_o.
//     W1C 0x2 -> STATUS=0.
//  5. ALARM=0x000010, CTRL=3; drive time_i 0x000009 -> 0x000010 -> irq_o=1, held for all
//     later cycles at 0x000010; W1C STATUS bit0 -> irq_o=0 with no re-fire.
//  6. Assert wb_rst_i mid-S_LOAD and mid-bus-cycle -> all outputs 0 immediately; no ack
//     after reset release.

Source files
------------

// File: rtl/rtc_ctrl_pkg.sv
// Shared constants and helpers for the RTC sequencer: register offsets,
// CTRL/STATUS bit positions, BCD digit fields and limits, FSM encodings.
package rtc_ctrl_pkg;

    // Register byte offsets from the Wishbone base address
    localparam logic [31:0] OFF_CTRL     = 32'h00;
    localparam logic [31:0] OFF_SET_TIME = 32'h04;
    localparam logic [31:0] OFF_ALARM    = 32'h08;
    localparam logic [31:0] OFF_STATUS   = 32'h0C;
    localparam logic [31:0] OFF_TIME     = 32'h10;
    localparam logic [31:0] OFF_PRESCALE = 32'h14;

    // CTRL and STATUS bit positions
    localparam int CTRL_RUN_BIT       = 0;
    localparam int CTRL_ALARM_EN_BIT  = 1;
    localparam int STATUS_ALARM_BIT   = 0;
    localparam int STATUS_SET_ERR_BIT = 1;

    // BCD digit field positions inside {hrm,hrl,minm,minl,secm,secl}
    localparam int HRM_LSB  = 20;
    localparam int HRL_LSB  = 16;
    localparam int MINM_LSB = 12;
    localparam int MINL_LSB = 8;
    localparam int SECM_LSB = 4;
    localparam int SECL_LSB = 0;

    // Largest legal value of each digit; hours in the 20s stop at 23
    localparam logic [3:0] HRM_MAX        = 4'd2;
    localparam logic [3:0] HRL_MAX        = 4'd9;
    localparam logic [3:0] HRL_MAX_IN_20S = 4'd3;
    localparam logic [3:0] MINM_MAX       = 4'd5;
    localparam logic [3:0] MINL_MAX       = 4'd9;
    localparam logic [3:0] SECM_MAX       = 4'd5;
    localparam logic [3:0] SECL_MAX       = 4'd9;

    // Sequencer state encodings
    localparam logic [1:0] S_STOP = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_LOAD = 2'd2;

    // True when a packed BCD time is a legal 24-hour hh:mm:ss value
    function automatic logic bcd_time_valid(input logic [23:0] t);
        logic [3:0] hrm;
        logic [3:0] hrl;
        logic [3:0] minm;
        logic [3:0] minl;
        logic [3:0] secm;
        logic [3:0] secl;
        hrm  = t[HRM_LSB  +: 4];
        hrl  = t[HRL_LSB  +: 4];
        minm = t[MINM_LSB +: 4];
        minl = t[MINL_LSB +: 4];
        secm = t[SECM_LSB +: 4];
        secl = t[SECL_LSB +: 4];
        return (hrm <= HRM_MAX) && (hrl <= HRL_MAX)
            && !((hrm == HRM_MAX) && (hrl > HRL_MAX_IN_20S))
            && (minm <= MINM_MAX) && (minl <= MINL_MAX)
            && (secm <= SECM_MAX) && (secl <= SECL_MAX);
    endfunction

    // Replace only the bytes whose select bit is set
    function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  sel);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/rtc_prescaler.sv
// Seconds-tick prescaler: counts bus clocks up to PRESCALE and emits a
// one-cycle tick on the terminal count. clear restarts the count from 0
// and suppresses the tick; with enable low the count simply holds.
module rtc_prescaler #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic         clear,
    input  logic [W-1:0] prescale,
    output logic         tick
);

    logic [W-1:0] cnt;
    logic         at_limit;

    // A limit lowered below cnt is only met after cnt rolls over through all-ones
    assign at_limit = (cnt == prescale);
    assign tick     = enable & ~clear & at_limit;

    // Count while enabled, restart on the terminal count or on a clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            if (at_limit) cnt <= '0;
            else          cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/rtc_ctrl.sv
// Wishbone-controlled sequencer for the BCD hh:mm:ss counter chain.
// Decodes the register file, validates and issues time loads, drives the
// seconds prescaler and raises a level alarm interrupt on a time match.
module rtc_ctrl #(
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
    parameter int          PRESCALE_W   = 24,
    parameter logic [PRESCALE_W-1:0] PRESCALE_RST = 24'd9_999_999
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic [23:0] time_i,
    output logic        tick_o,
    output logic        load_o,
    output logic [23:0] load_time_o,
    output logic        irq_o
);
    import rtc_ctrl_pkg::*;

    logic                  ctrl_run;
    logic                  ctrl_alarm_en;
    logic [23:0]           alarm_time;
    logic                  alarm_flag;
    logic                  set_err;
    logic [PRESCALE_W-1:0] prescale;
    logic [1:0]            state;
    logic [1:0]            state_next;
    logic [23:0]           load_time;
    logic                  match_q;
    logic                  match_prev;

    logic [31:0] offset;
    logic        req;
    logic        wr_req;
    logic        hit_ctrl;
    logic        hit_set_time;
    logic        hit_alarm;
    logic        hit_status;
    logic        hit_prescale;
    logic [31:0] rd_data;
    logic [31:0] set_word;
    logic [31:0] alarm_word;
    logic [31:0] pre_word;
    logic        time_ok;
    logic        set_time_go;
    logic        set_time_bad;
    logic        status_clr_alarm;
    logic        status_clr_err;
    logic        alarm_rise;
    logic        unused_bits;

    // A new request is one not already being acknowledged, so a held strobe acks every other cycle
    assign offset = wbs_adr_i - BASE_ADDR;
    assign req    = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign wr_req = req & wbs_we_i;

    assign hit_ctrl     = (offset == OFF_CTRL);
    assign hit_set_time = (offset == OFF_SET_TIME);
    assign hit_alarm    = (offset == OFF_ALARM);
    assign hit_status   = (offset == OFF_STATUS);
    assign hit_prescale = (offset == OFF_PRESCALE);

    // Partial writes keep the unselected bytes; SET_TIME merges over the last loaded time
    assign set_word   = byte_merge({8'h00, load_time}, wbs_dat_i, wbs_sel_i);
    assign alarm_word = byte_merge({8'h00, alarm_time}, wbs_dat_i, wbs_sel_i);
    assign pre_word   = byte_merge(32'(prescale), wbs_dat_i, wbs_sel_i);
    assign unused_bits = ^{set_word[31:24], alarm_word[31:24], pre_word[31:PRESCALE_W]};

    assign time_ok      = bcd_time_valid(set_word[23:0]);
    assign set_time_go  = wr_req & hit_set_time & time_ok;
    assign set_time_bad = wr_req & hit_set_time & ~time_ok;

    assign status_clr_alarm = wr_req & hit_status & wbs_sel_i[0] & wbs_dat_i[STATUS_ALARM_BIT];
    assign status_clr_err   = wr_req & hit_status & wbs_sel_i[0] & wbs_dat_i[STATUS_SET_ERR_BIT];

    // Read mux: SET_TIME, unused bits and unmapped offsets all read as zero
    always_comb begin
        rd_data = 32'h0;
        case (offset)
            OFF_CTRL: begin
                rd_data[CTRL_RUN_BIT]      = ctrl_run;
                rd_data[CTRL_ALARM_EN_BIT] = ctrl_alarm_en;
            end
            OFF_ALARM:    rd_data = {8'h00, alarm_time};
            OFF_STATUS: begin
                rd_data[STATUS_ALARM_BIT]   = alarm_flag;
                rd_data[STATUS_SET_ERR_BIT] = set_err;
            end
            OFF_TIME:     rd_data = {8'h00, time_i};
            OFF_PRESCALE: rd_data = 32'(prescale);
            default:      rd_data = 32'h0;
        endcase
    end

    // Registered one-cycle acknowledge with read data captured alongside it
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= 32'h0;
        end else begin
            wbs_ack_o <= req;
            wbs_dat_o <= (req & ~wbs_we_i) ? rd_data : 32'h0;
        end
    end

    // Plain read/write configuration registers, updated on the edge that raises ack
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ctrl_run      <= 1'b0;
            ctrl_alarm_en <= 1'b0;
            alarm_time    <= 24'h0;
            prescale      <= PRESCALE_RST;
        end else if (wr_req) begin
            if (hit_ctrl && wbs_sel_i[0]) begin
                ctrl_run      <= wbs_dat_i[CTRL_RUN_BIT];
                ctrl_alarm_en <= wbs_dat_i[CTRL_ALARM_EN_BIT];
            end
            if (hit_alarm)    alarm_time <= alarm_word[23:0];
            if (hit_prescale) prescale   <= pre_word[PRESCALE_W-1:0];
        end
    end

    // Sticky status flags; a new alarm in the same cycle as its clear wins
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            alarm_flag <= 1'b0;
            set_err    <= 1'b0;
        end else begin
            if (alarm_rise)            alarm_flag <= 1'b1;
            else if (status_clr_alarm) alarm_flag <= 1'b0;
            if (set_time_bad)          set_err    <= 1'b1;
            else if (status_clr_err)   set_err    <= 1'b0;
        end
    end

    // Registered match and its previous value so the flag fires only on the rising edge
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            match_q    <= 1'b0;
            match_prev <= 1'b0;
        end else begin
            match_q    <= (time_i == alarm_time) & ctrl_alarm_en;
            match_prev <= match_q;
        end
    end

    assign alarm_rise = match_q & ~match_prev;
    assign irq_o      = alarm_flag & ctrl_alarm_en;

    // Next-state logic: a valid SET_TIME pre-empts the run/stop decision
    always_comb begin
        state_next = state;
        case (state)
            S_STOP:  if (ctrl_run)  state_next = S_RUN;
            S_RUN:   if (!ctrl_run) state_next = S_STOP;
            S_LOAD:  state_next = ctrl_run ? S_RUN : S_STOP;
            default: state_next = S_STOP;
        endcase
        if (set_time_go) state_next = S_LOAD;
    end

    // State register and the value presented to the counter chain during the load cycle
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= S_STOP;
            load_time <= 24'h0;
        end else begin
            state <= state_next;
            if (set_time_go) load_time <= set_word[23:0];
        end
    end

    assign load_o      = (state == S_LOAD);
    assign load_time_o = load_time;

    rtc_prescaler #(
        .W (PRESCALE_W)
    ) u_prescaler (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .enable   (ctrl_run & (state != S_LOAD)),
        .clear    (state == S_LOAD),
        .prescale (prescale),
        .tick     (tick_o)
    );

endmodule

// File: tb/tb_rtc_ctrl.sv
// Scoreboard bench for rtc_ctrl: bus reads and loads push expected values
// into queues, and independent monitors pop and compare them whenever the
// DUT acknowledges or strobes load_o.
module tb_rtc_ctrl;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [23:0] time_i;
    logic        tick_o, load_o, irq_o;
    logic [23:0] load_time_o;

    int checks   = 0;
    int failures = 0;
    int cyc_n    = 0;
    int last_ack = 0;
    int load_cyc = -1;

    typedef struct {
        logic        chk;
        logic [31:0] exp;
        string       name;
    } ack_exp_t;

    ack_exp_t    ack_q[$];
    logic [23:0] load_q[$];
    int          tick_q[$];

    rtc_ctrl #(
        .BASE_ADDR    (BASE),
        .PRESCALE_W   (24),
        .PRESCALE_RST (24'd9_999_999)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wbs_cyc_i   (wbs_cyc_i),
        .wbs_stb_i   (wbs_stb_i),
        .wbs_we_i    (wbs_we_i),
        .wbs_sel_i   (wbs_sel_i),
        .wbs_adr_i   (wbs_adr_i),
        .wbs_dat_i   (wbs_dat_i),
        .wbs_ack_o   (wbs_ack_o),
        .wbs_dat_o   (wbs_dat_o),
        .time_i      (time_i),
        .tick_o      (tick_o),
        .load_o      (load_o),
        .load_time_o (load_time_o),
        .irq_o       (irq_o)
    );

    always #5 clk = ~clk;

    // Cycle index of the most recent rising edge
    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    // Ack monitor: every acknowledge consumes one scoreboard entry
    always @(negedge clk) begin
        if (!rst && wbs_ack_o) begin
            if (ack_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_ack: got ack=1, expected no ack");
            end else begin
                ack_exp_t e;
                e = ack_q.pop_front();
                if (e.chk) checkOutput(e.name, wbs_dat_o, e.exp);
            end
        end
    end

    // Load monitor: every load strobe consumes one expected load value
    always @(negedge clk) begin
        if (!rst && load_o) begin
            load_cyc = cyc_n;
            if (load_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_load: got load_o=1 with 0x%06h, expected no load", load_time_o);
            end else begin
                checkOutput("load_time", {8'h00, load_time_o}, {8'h00, load_q.pop_front()});
            end
        end
    end

    // Tick recorder
    always @(negedge clk) begin
        if (!rst && tick_o) tick_q.push_back(cyc_n);
    end

    // One bus transaction with a bounded wait for ack
    task automatic applyStimulus(input logic we, input logic [31:0] off, input logic [31:0] dat,
                                 input logic [3:0] sel, input logic [31:0] exp, input string name);
        ack_exp_t e;
        bit got;
        e.chk  = ~we;
        e.exp  = exp;
        e.name = name;
        ack_q.push_back(e);
        @(negedge clk);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = BASE + off;
        wbs_dat_i = dat;
        wbs_sel_i = sel;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (wbs_ack_o) begin
                got = 1'b1;
                last_ack = cyc_n;
            end
        end
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        if (!got) begin
            checks++;
            failures++;
            $display("[TB] FAIL ack_timeout_%s: got no ack in 8 cycles, expected ack", name);
            void'(ack_q.pop_back());
        end
    endtask

    task automatic wb_write(input logic [31:0] off, input logic [31:0] dat, input logic [3:0] sel = 4'hF);
        applyStimulus(1'b1, off, dat, sel, 32'h0, "write");
    endtask

    task automatic wb_read(input logic [31:0] off, input logic [31:0] exp, input string name);
        applyStimulus(1'b0, off, 32'h0, 4'hF, exp, name);
    endtask

    // Safety net so the run always ends
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int e1, e2, e3, ld, first, hi;
        rst = 1'b1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        wbs_sel_i = 4'h0; wbs_adr_i = 32'h0; wbs_dat_i = 32'h0;
        time_i = 24'h0;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_ack",       {31'h0, wbs_ack_o}, 32'h0);
        checkOutput("rst_dat",       wbs_dat_o, 32'h0);
        checkOutput("rst_tick",      {31'h0, tick_o}, 32'h0);
        checkOutput("rst_load",      {31'h0, load_o}, 32'h0);
        checkOutput("rst_irq",       {31'h0, irq_o}, 32'h0);
        checkOutput("rst_load_time", {8'h00, load_time_o}, 32'h0);
        rst = 1'b0;

        wb_read(32'h14, 32'h0098_967F, "prescale_reset");
        wb_read(32'h00, 32'h0, "ctrl_reset");
        wb_read(32'h0C, 32'h0, "status_reset");
        hi = 0;
        repeat (10) begin
            @(negedge clk);
            hi += int'(tick_o) + int'(irq_o);
        end
        checkOutput("idle_tick_irq", hi, 0);

        // Register map odds and ends
        time_i = 24'h123456;
        wb_read(32'h10, 32'h0012_3456, "time_read");
        wb_read(32'h04, 32'h0, "set_time_reads_zero");
        wb_read(32'h18, 32'h0, "unmapped_reads_zero");
        wb_write(32'h08, 32'h00AA_BBCC);
        wb_write(32'h08, 32'h0011_2233, 4'b0001);
        wb_read(32'h08, 32'h00AA_BB33, "alarm_byte_lane");

        // Prescaler period, stop/hold and resume
        wb_write(32'h14, 32'd3);
        tick_q.delete();
        wb_write(32'h00, 32'h1);
        e1 = last_ack;
        repeat (16) @(negedge clk);
        checkOutput("tick_count_run", tick_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < tick_q.size()) checkOutput($sformatf("tick_time_%0d", i), tick_q[i], e1 + 3 + 4*i);
        end
        wb_write(32'h00, 32'h0);
        e2 = last_ack;
        tick_q.delete();
        repeat (10) @(negedge clk);
        checkOutput("tick_count_stopped", tick_q.size(), 0);
        wb_write(32'h00, 32'h1);
        e3 = last_ack;
        repeat (8) @(negedge clk);
        checkOutput("tick_after_resume", (tick_q.size() > 0) ? tick_q[0] : -1,
                    e3 + 3 - ((e2 - e1) % 4));

        // Valid time load and tick realignment
        tick_q.delete();
        load_q.push_back(24'h235959);
        wb_write(32'h04, 32'h0023_5959);
        ld = last_ack;
        repeat (8) @(negedge clk);
        checkOutput("load_cycle", load_cyc, ld);
        first = -1;
        foreach (tick_q[i]) begin
            if (tick_q[i] >= ld && first < 0) first = tick_q[i];
        end
        checkOutput("tick_after_load", first, ld + 4);
        checkOutput("load_time_hold", {8'h00, load_time_o}, 32'h0023_5959);
        wb_write(32'h00, 32'h0);

        // Invalid times flag SET_ERR and never load
        wb_write(32'h04, 32'h0024_0000);
        wb_read(32'h0C, 32'h2, "set_err_hour24");
        wb_write(32'h0C, 32'h2);
        wb_read(32'h0C, 32'h0, "set_err_cleared");
        wb_write(32'h04, 32'h0012_6000);
        wb_read(32'h0C, 32'h2, "set_err_min60");
        wb_write(32'h0C, 32'h2);
        wb_read(32'h0C, 32'h0, "set_err_cleared2");

        // Alarm match, hold, W1C without re-fire, masking
        wb_write(32'h08, 32'h0000_0010);
        time_i = 24'h000009;
        wb_write(32'h00, 32'h3);
        repeat (4) @(negedge clk);
        checkOutput("irq_no_match", {31'h0, irq_o}, 32'h0);
        time_i = 24'h000010;
        repeat (4) @(negedge clk);
        checkOutput("irq_on_match", {31'h0, irq_o}, 32'h1);
        hi = 0;
        repeat (6) begin
            @(negedge clk);
            hi += int'(irq_o);
        end
        checkOutput("irq_held", hi, 6);
        wb_read(32'h0C, 32'h1, "status_alarm");
        wb_write(32'h0C, 32'h1);
        hi = 0;
        repeat (10) begin
            @(negedge clk);
            hi += int'(irq_o);
        end
        checkOutput("irq_no_refire", hi, 0);
        time_i = 24'h000009;
        repeat (3) @(negedge clk);
        time_i = 24'h000010;
        repeat (4) @(negedge clk);
        checkOutput("irq_second_match", {31'h0, irq_o}, 32'h1);
        wb_write(32'h00, 32'h1);
        repeat (2) @(negedge clk);
        checkOutput("irq_masked", {31'h0, irq_o}, 32'h0);
        wb_read(32'h0C, 32'h1, "flag_kept_masked");
        wb_write(32'h0C, 32'h1);
        wb_read(32'h0C, 32'h0, "status_clear");

        // Reset during the load cycle and during an acknowledged bus cycle
        wb_write(32'h00, 32'h3);
        repeat (4) @(negedge clk);
        checkOutput("irq_before_reset", {31'h0, irq_o}, 32'h1);
        @(negedge clk);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
        wbs_adr_i = BASE + 32'h04; wbs_dat_i = 32'h0012_3456; wbs_sel_i = 4'hF;
        @(posedge clk);
        #2;
        checkOutput("load_before_reset", {31'h0, load_o}, 32'h1);
        checkOutput("ack_before_reset",  {31'h0, wbs_ack_o}, 32'h1);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_ack",       {31'h0, wbs_ack_o}, 32'h0);
        checkOutput("mid_rst_load",      {31'h0, load_o}, 32'h0);
        checkOutput("mid_rst_tick",      {31'h0, tick_o}, 32'h0);
        checkOutput("mid_rst_irq",       {31'h0, irq_o}, 32'h0);
        checkOutput("mid_rst_dat",       wbs_dat_o, 32'h0);
        checkOutput("mid_rst_load_time", {8'h00, load_time_o}, 32'h0);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        hi = 0;
        repeat (10) begin
            @(negedge clk);
            hi += int'(wbs_ack_o) + int'(load_o) + int'(tick_o) + int'(irq_o);
        end
        checkOutput("quiet_after_reset", hi, 0);
        wb_read(32'h14, 32'h0098_967F, "prescale_after_reset");
        wb_read(32'h00, 32'h0, "ctrl_after_reset");

        repeat (2) @(negedge clk);
        checkOutput("ack_queue_drained",  ack_q.size(), 0);
        checkOutput("load_queue_drained", load_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
